// File: rtl/sign_condition_unit_if.sv
// Purpose  : operand/condition input handshake and classification result output handshake.
// Latency  : n/a (signal bundle only).
// Backpres.: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Signals:
//   in_valid, in_ready, in_data[WIDTH-1:0], in_cond[2:0]   producer -> unit
//   out_valid, out_ready, out_lt, out_eq, out_gt, out_jump unit -> consumer
// master = producer/consumer side (testbench or surrounding logic), slave = the unit.
interface sign_condition_unit_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_cond;
  logic             out_valid;
  logic             out_ready;
  logic             out_lt;
  logic             out_eq;
  logic             out_gt;
  logic             out_jump;

  modport master (
    output in_valid, in_data, in_cond, out_ready,
    input  in_ready, out_valid, out_lt, out_eq, out_gt, out_jump
  );

  modport slave (
    input  in_valid, in_data, in_cond, out_ready,
    output in_ready, out_valid, out_lt, out_eq, out_gt, out_jump
  );
endinterface

// File: rtl/sign_condition_unit.sv
// Purpose  : classify a signed operand as lt/eq/gt, evaluate a {gt,eq,lt} jump mask, count negatives.
// Latency  : 1 cycle from accept to out_valid; 1 result per cycle while out_ready is high.
// Backpres.: in_ready = ~rst & (~out_valid | out_ready); no skid buffer, a stalled result holds.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   bus (slave)       in_valid/in_ready/in_data/in_cond, out_valid/out_ready/out_lt/out_eq/out_gt/out_jump
//   clr_count         synchronous clear of neg_count (a same-cycle negative accept still counts)
//   neg_count         saturating count of accepted negative operands
// Optional feature macro SIGN_COND_STICKY_FLAGS_EN adds:
//   sticky_clr        clears sticky_flags (same-cycle accepted flags still set)
//   sticky_flags      OR of {gt,eq,lt} over all accepted operands
module sign_condition_unit #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sign_condition_unit_if.slave bus,
  input  logic                 clr_count,
  output logic [CNT_WIDTH-1:0] neg_count
`ifdef SIGN_COND_STICKY_FLAGS_EN
  ,
  input  logic [0:0]           sticky_clr,
  output logic [2:0]           sticky_flags
`endif
);

  logic                 lt, eq, gt, jump;
  logic                 ready, accept;
  logic                 valid_q, valid_d;
  logic [3:0]           flags_q, flags_d;   // {jump, gt, eq, lt}
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Classification: the sign bit alone decides lt, so the most negative value is lt.
  assign lt   = bus.in_data[WIDTH-1];
  assign eq   = (bus.in_data == '0);
  assign gt   = ~lt & ~eq;
  assign jump = |(bus.in_cond & {gt, eq, lt});

  // Depth-1 register: a slot is free when empty or being drained this cycle.
  assign ready  = ~rst & (~valid_q | bus.out_ready);
  assign accept = bus.in_valid & ready;

  always_comb begin
    valid_d = valid_q;
    flags_d = flags_q;
    if (accept) begin
      valid_d = 1'b1;
      flags_d = {jump, gt, eq, lt};
    end else if (valid_q & bus.out_ready) begin
      // Drain only drops valid; the flag bits keep their last value.
      valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = CNT_WIDTH'(accept & lt);
    end else if (accept & lt & ~(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SIGN_COND_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_clr[0] ? 3'b000 : sticky_q;
    if (accept) begin
      sticky_d = sticky_d | {gt, eq, lt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`endif

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_lt    = flags_q[0];
  assign bus.out_eq    = flags_q[1];
  assign bus.out_gt    = flags_q[2];
  assign bus.out_jump  = flags_q[3];
  assign neg_count     = cnt_q;

endmodule

// File: tb/tb_sign_condition_unit.sv
module tb_sign_condition_unit;

  logic       clk;
  logic       rst;
  logic       clr_count;
  logic [1:0] neg_count;
  logic [0:0] sticky_clr;
  logic [2:0] sticky_flags;

  sign_condition_unit_if #(.WIDTH(16)) bus ();

  sign_condition_unit #(
    .WIDTH     (16),
    .CNT_WIDTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .clr_count    (clr_count),
    .neg_count    (neg_count)
`ifdef SIGN_COND_STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected {jump,gt,eq,lt}; last accepted value is what the flags hold after drain.
  logic [3:0] q[$];
  logic [3:0] last_m   = 4'b0000;
  logic [1:0] cnt_m    = 2'd0;
  logic [2:0] sticky_m = 3'b000;

  function automatic logic [3:0] expect_flags(input logic [15:0] d, input logic [2:0] c);
    logic l, e, g, j;
    l = d[15];
    e = (d == 16'h0000);
    g = !l && !e;
    j = (c[0] && l) || (c[1] && e) || (c[2] && g);
    return {j, g, e, l};
  endfunction

  // One clock: drive at negedge, check in_ready, update model, check registered outputs next negedge.
  task automatic cycle(input logic r, input logic v, input logic [15:0] d, input logic [2:0] c,
                       input logic ordy, input logic clr, input logic sclr);
    logic       exp_rdy, acc, drn;
    logic [3:0] e, obs, want, dummy;
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_cond  = c;
    bus.out_ready = ordy;
    clr_count    = clr;
    sticky_clr   = sclr;
    #1;
    exp_rdy = !r && (q.size() == 0 || ordy);
    total++;
    if (bus.in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL in_ready t=%0t: got %b want %b", $time, bus.in_ready, exp_rdy);
    end
    acc = v && exp_rdy;
    drn = (q.size() != 0) && ordy;
    e   = expect_flags(d, c);
    if (r) begin
      q.delete();
      last_m   = 4'b0000;
      cnt_m    = 2'd0;
      sticky_m = 3'b000;
    end else begin
      if (drn) dummy = q.pop_front();
      if (acc) begin
        q.push_back(e);
        last_m = e;
      end
      if (clr) cnt_m = (acc && e[0]) ? 2'd1 : 2'd0;
      else if (acc && e[0] && cnt_m != 2'd3) cnt_m = cnt_m + 2'd1;
      sticky_m = (sclr ? 3'b000 : sticky_m) | (acc ? e[2:0] : 3'b000);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== (q.size() != 0)) begin
      bad++;
      $display("FAIL out_valid t=%0t: got %b want %b", $time, bus.out_valid, (q.size() != 0));
    end
    obs  = {bus.out_jump, bus.out_gt, bus.out_eq, bus.out_lt};
    want = (q.size() != 0) ? q[0] : last_m;
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL flags{jump,gt,eq,lt} t=%0t: got %b want %b", $time, obs, want);
    end
    total++;
    if (neg_count !== cnt_m) begin
      bad++;
      $display("FAIL neg_count t=%0t: got %0d want %0d", $time, neg_count, cnt_m);
    end
`ifdef SIGN_COND_STICKY_FLAGS_EN
    total++;
    if (sticky_flags !== sticky_m) begin
      bad++;
      $display("FAIL sticky_flags t=%0t: got %b want %b", $time, sticky_flags, sticky_m);
    end
`endif
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'h8000, 3'b111, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.out_valid !== 1'b0 || neg_count !== 2'd0 || bus.out_lt !== 1'b0 || bus.out_jump !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b cnt=%0d lt=%b jump=%b want all 0",
               bus.out_valid, neg_count, bus.out_lt, bus.out_jump);
    end
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_classify();
    logic [15:0] vals [4];
    vals[0] = 16'h8000; vals[1] = 16'h0000; vals[2] = 16'h7FFF; vals[3] = 16'hFFFF;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, vals[i], 3'b001, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
    // mask 000 never jumps, 111 always jumps
    cycle(1'b0, 1'b1, 16'h1234, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000, 3'b111, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0001, 3'b010, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    cycle(1'b0, 1'b1, 16'h0005, 3'b100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 16'h8000 + 16'(i), 3'b001, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus.out_gt !== 1'b1 || bus.out_jump !== 1'b1 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold: got gt=%b jump=%b v=%b want 1 1 1", bus.out_gt, bus.out_jump, bus.out_valid);
      end
    end
    cycle(1'b0, 1'b1, 16'hFFFE, 3'b001, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    logic [1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd3; seq[4] = 2'd3;
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 16'hFF00 - 16'(i), 3'b001, 1'b1, 1'b0, 1'b0);
      total++;
      if (neg_count !== seq[i]) begin
        bad++;
        $display("FAIL sat_seq[%0d]: got %0d want %0d", i, neg_count, seq[i]);
      end
    end
    cycle(1'b0, 1'b1, 16'h8001, 3'b001, 1'b1, 1'b1, 1'b0);
    total++;
    if (neg_count !== 2'd1) begin
      bad++;
      $display("FAIL clr_with_accept: got %0d want 1", neg_count);
    end
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midstall();
    cycle(1'b0, 1'b1, 16'hC000, 3'b001, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h9000, 3'b111, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.out_valid !== 1'b0 || neg_count !== 2'd0) begin
      bad++;
      $display("FAIL midstall_reset: got v=%b cnt=%0d want 0 0", bus.out_valid, neg_count);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0));
    end
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef SIGN_COND_STICKY_FLAGS_EN
  task automatic test_sticky();
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 16'hFFFD, 3'b001, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000, 3'b001, 1'b1, 1'b0, 1'b0);
    total++;
    if (sticky_flags !== 3'b011) begin
      bad++;
      $display("FAIL sticky_accum: got %b want 011", sticky_flags);
    end
    cycle(1'b0, 1'b1, 16'h0007, 3'b001, 1'b1, 1'b0, 1'b1);
    total++;
    if (sticky_flags !== 3'b100) begin
      bad++;
      $display("FAIL sticky_clr_same_cycle: got %b want 100", sticky_flags);
    end
    cycle(1'b0, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_cond   = 3'b000;
    bus.out_ready = 1'b0;
    clr_count     = 1'b0;
    sticky_clr    = 1'b0;
    test_reset();
    test_classify();
    test_backpressure();
    test_saturation();
    test_reset_midstall();
    test_back_to_back();
`ifdef SIGN_COND_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
